// File: rtl/my_spi_pkg.sv
// Shared types and constants for the SPI register link (master side and slave-facing addresses).
package my_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    LOW,
    HIGH,
    CS_HOLD,
    GAP,
    DONE
  } spi_state_e;

  localparam int FRAME_BITS = 32;
  localparam int CMD_BITS   = 16;
  localparam int WR_BIT     = 15;

  // Register map of the FPGA SPI register slave
  localparam logic [14:0] REG_STATUS  = 15'h001;
  localparam logic [14:0] REG_LED70   = 15'h002;
  localparam logic [14:0] REG_SCRATCH = 15'h011;

  function automatic logic [FRAME_BITS-1:0] make_frame(input logic wr,
                                                       input logic [14:0] addr,
                                                       input logic [15:0] wdata);
    return {wr, addr, wdata};
  endfunction

endpackage

// File: rtl/my_spi_master_if.sv
// Host-side start/busy/done handshake of the SPI master.
interface my_spi_master_if;
  import my_spi_pkg::*;

  logic        start;
  logic        wr;
  logic [14:0] addr;
  logic [15:0] wdata;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;

  modport master (output start, wr, addr, wdata, input rd_data, busy, done);
  modport slave  (input start, wr, addr, wdata, output rd_data, busy, done);

endinterface

// File: rtl/my_spi_master_sync2.sv
// Two-flop synchroniser for asynchronous inputs into the theClock domain.
module my_spi_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             theClock,
  input  logic             theReset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge theClock) begin
    if (theReset) begin
      meta   <= '0;
      synced <= '0;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/my_spi_master.sv
// Mode-0 SPI master sending 32-bit {wr, addr, data} frames to the FPGA register slave;
// a one-period CS_SETUP pause separates the command half from the data half.
module my_spi_master
  import my_spi_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic           theClock,
  input  logic           theReset,
  my_spi_master_if.slave host,
  output logic           spi_clk,
  output logic           spi_cs,
  output logic           spi_sdo,
  input  logic           spi_sdi
);

  localparam logic [8:0] DIV_LOAD    = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LOAD    = 9'(2 * CLK_DIV - 1);
  localparam logic [5:0] CMD_COUNT   = 6'(CMD_BITS);
  localparam logic [5:0] FRAME_COUNT = 6'(FRAME_BITS);

  spi_state_e      state, state_next;
  logic [8:0]      div_cnt, div_next;
  logic [5:0]      bit_cnt, bit_next, bit_inc;
  logic [31:0]     tx, tx_next;
  logic [15:0]     rx, rx_next, rd_data;
  logic            sdi_sync, div_last, accept;
  logic            cs_next, clk_next, sdo_next;

  my_spi_sync2 #(.WIDTH(1)) u_sdi_sync (
    .theClock (theClock),
    .theReset (theReset),
    .raw      (spi_sdi),
    .synced   (sdi_sync)
  );

  always_comb begin
    state_next = state;
    div_next   = div_cnt;
    bit_next   = bit_cnt;
    tx_next    = tx;
    rx_next    = rx;
    bit_inc    = bit_cnt + 6'd1;
    div_last   = (div_cnt == '0);
    accept     = host.start && (state == IDLE || state == DONE);

    case (state)
      IDLE: state_next = IDLE;
      CS_SETUP: if (div_last) begin
        state_next = HIGH;
        if (bit_cnt >= CMD_COUNT) rx_next = {rx[14:0], sdi_sync};
      end
      HIGH: if (div_last) begin
        bit_next = bit_inc;
        if (bit_inc == FRAME_COUNT) begin
          state_next = CS_HOLD;
        end else begin
          state_next = LOW;
          tx_next    = {tx[30:0], 1'b0};
        end
      end
      // The low half after the last command bit hands over to the mid-frame CS_SETUP pause
      LOW: if (div_last) begin
        if (bit_cnt >= CMD_COUNT) rx_next = {rx[14:0], sdi_sync};
        state_next = (bit_cnt == CMD_COUNT) ? CS_SETUP : HIGH;
      end
      CS_HOLD: if (div_last) state_next = GAP;
      GAP:     if (div_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (accept) begin
      state_next = CS_SETUP;
      tx_next    = make_frame(host.wr, host.addr, host.wdata);
      bit_next   = '0;
    end

    if (state_next != state) begin
      case (state_next)
        GAP:                         div_next = GAP_LOAD;
        CS_SETUP, LOW, HIGH, CS_HOLD: div_next = DIV_LOAD;
        default:                     div_next = '0;
      endcase
    end else if (!div_last) begin
      div_next = div_cnt - 9'd1;
    end

    // Pins are registered from the next state so they switch cleanly with the FSM
    cs_next  = !(state_next inside {CS_SETUP, LOW, HIGH, CS_HOLD});
    clk_next = (state_next == HIGH);
    sdo_next = (state_next inside {CS_SETUP, LOW, HIGH}) && tx_next[31];
  end

  always_ff @(posedge theClock) begin
    if (theReset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      rx      <= '0;
      rd_data <= '0;
      spi_cs  <= 1'b1;
      spi_clk <= 1'b0;
      spi_sdo <= 1'b0;
    end else begin
      state   <= state_next;
      div_cnt <= div_next;
      bit_cnt <= bit_next;
      tx      <= tx_next;
      rx      <= rx_next;
      spi_cs  <= cs_next;
      spi_clk <= clk_next;
      spi_sdo <= sdo_next;
      if (state_next == DONE) rd_data <= rx_next;
    end
  end

  assign host.rd_data = rd_data;
  assign host.busy    = (state != IDLE) && (state != DONE);
  assign host.done    = (state == DONE);

endmodule
